// File: rtl/ProtocolInfo.sv
// DM9000A register indices, bus cycle encodings and framer state enum.
package ProtocolInfo;

  localparam logic [7:0]  REG_MWCMD = 8'hF8;
  localparam logic [7:0]  REG_TXPLL = 8'hFC;
  localparam logic [7:0]  REG_TXPLH = 8'hFD;
  localparam logic [7:0]  REG_TCR   = 8'h02;
  localparam logic [15:0] TCR_TXREQ = 16'h0001;

  localparam logic MODE_INDEX = 1'b0;
  localparam logic MODE_DATA  = 1'b1;

  typedef enum logic [3:0] {
    IDLE,
    IDX_MWCMD,
    GET_LO,
    GET_HI,
    WR_WORD,
    PAD,
    IDX_TXPLL,
    DAT_TXPLL,
    IDX_TXPLH,
    DAT_TXPLH,
    IDX_TCR,
    DAT_TCR
  } state_t;

  // Index cycles carry the register number in the low byte.
  function automatic logic [15:0] index_word(input logic [7:0] idx);
    return {8'h00, idx};
  endfunction

endpackage

// File: rtl/dm9000a_tx_framer.sv
// Turns a byte stream into DM9000A TX FIFO writes plus the length/TCR tail.
module dm9000a_tx_framer
  import ProtocolInfo::*;
#(
  parameter int unsigned MAX_FRAME_BYTES = 1514,
  parameter int unsigned MIN_FRAME_BYTES = 60
) (
  input  logic        clk100,
  input  logic        reset,
  input  logic        in_valid,
  input  logic [7:0]  in_data,
  input  logic        in_last,
  output logic        in_ready,
  output logic        bus_req,
  output logic        bus_mode,
  output logic [15:0] bus_value,
  input  logic        bus_done,
  output logic        busy,
  output logic        frame_sent,
  output logic        err_len
);

  localparam int unsigned CNT_W = 16;
  localparam logic [CNT_W-1:0] MAX_LEN = CNT_W'(MAX_FRAME_BYTES);
  localparam logic [CNT_W-1:0] MIN_LEN = CNT_W'(MIN_FRAME_BYTES);

  state_t           state, state_d;
  logic [CNT_W-1:0] count, count_d;
  logic [CNT_W-1:0] pad_len, pad_len_d;
  logic             ovf, ovf_d;
  logic             last, last_d;
  logic             in_ready_d, bus_req_d, bus_mode_d, busy_d, frame_sent_d, err_len_d;
  logic [15:0]      bus_value_d;

  logic             accept;
  logic             done;
  logic [CNT_W-1:0] len;
  state_t           after_data;

  assign accept     = in_valid & in_ready;
  assign done       = bus_req & bus_done;
  assign len        = ovf ? MAX_LEN : ((count < MIN_LEN) ? MIN_LEN : count);
  assign after_data = (count < MIN_LEN) ? PAD : IDX_TXPLL;

  // Next-state and next-output logic; every bus state raises req once, then waits for done.
  always_comb begin
    state_d      = state;
    count_d      = count;
    pad_len_d    = pad_len;
    ovf_d        = ovf;
    last_d       = last;
    bus_req_d    = bus_req;
    bus_mode_d   = bus_mode;
    bus_value_d  = bus_value;
    busy_d       = busy;
    frame_sent_d = 1'b0;
    err_len_d    = 1'b0;

    if (accept) begin
      busy_d = 1'b1;
    end

    case (state)
      IDLE: begin
        count_d   = '0;
        pad_len_d = '0;
        ovf_d     = 1'b0;
        last_d    = 1'b0;
        if (in_valid) begin
          state_d = IDX_MWCMD;
        end
      end

      IDX_MWCMD: begin
        if (!bus_req) begin
          bus_req_d   = 1'b1;
          bus_mode_d  = MODE_INDEX;
          bus_value_d = index_word(REG_MWCMD);
        end else if (done) begin
          bus_req_d = 1'b0;
          state_d   = GET_LO;
        end
      end

      GET_LO: begin
        if (accept) begin
          if (ovf || (count == MAX_LEN)) begin
            // Excess bytes are drained but never written.
            err_len_d = ~ovf;
            ovf_d     = 1'b1;
            if (in_last) begin
              state_d   = after_data;
              pad_len_d = count + CNT_W'(count[0]);
            end
          end else begin
            count_d     = count + CNT_W'(1);
            bus_value_d = {8'h00, in_data};
            if (in_last) begin
              last_d  = 1'b1;
              state_d = WR_WORD;
            end else begin
              state_d = GET_HI;
            end
          end
        end
      end

      GET_HI: begin
        if (accept) begin
          if (count == MAX_LEN) begin
            // Flush the pending low byte alone; high byte stays zero.
            err_len_d = ~ovf;
            ovf_d     = 1'b1;
          end else begin
            count_d           = count + CNT_W'(1);
            bus_value_d[15:8] = in_data;
          end
          last_d  = in_last;
          state_d = WR_WORD;
        end
      end

      WR_WORD: begin
        if (!bus_req) begin
          bus_req_d  = 1'b1;
          bus_mode_d = MODE_DATA;
        end else if (done) begin
          bus_req_d = 1'b0;
          if (last) begin
            state_d   = after_data;
            pad_len_d = count + CNT_W'(count[0]);
          end else begin
            state_d = GET_LO;
          end
        end
      end

      PAD: begin
        if (!bus_req) begin
          bus_req_d   = 1'b1;
          bus_mode_d  = MODE_DATA;
          bus_value_d = 16'h0000;
        end else if (done) begin
          bus_req_d = 1'b0;
          pad_len_d = pad_len + CNT_W'(2);
          if ((pad_len + CNT_W'(2)) >= MIN_LEN) begin
            state_d = IDX_TXPLL;
          end
        end
      end

      IDX_TXPLL: begin
        if (!bus_req) begin
          bus_req_d   = 1'b1;
          bus_mode_d  = MODE_INDEX;
          bus_value_d = index_word(REG_TXPLL);
        end else if (done) begin
          bus_req_d = 1'b0;
          state_d   = DAT_TXPLL;
        end
      end

      DAT_TXPLL: begin
        if (!bus_req) begin
          bus_req_d   = 1'b1;
          bus_mode_d  = MODE_DATA;
          bus_value_d = {8'h00, len[7:0]};
        end else if (done) begin
          bus_req_d = 1'b0;
          state_d   = IDX_TXPLH;
        end
      end

      IDX_TXPLH: begin
        if (!bus_req) begin
          bus_req_d   = 1'b1;
          bus_mode_d  = MODE_INDEX;
          bus_value_d = index_word(REG_TXPLH);
        end else if (done) begin
          bus_req_d = 1'b0;
          state_d   = DAT_TXPLH;
        end
      end

      DAT_TXPLH: begin
        if (!bus_req) begin
          bus_req_d   = 1'b1;
          bus_mode_d  = MODE_DATA;
          bus_value_d = {8'h00, len[15:8]};
        end else if (done) begin
          bus_req_d = 1'b0;
          state_d   = IDX_TCR;
        end
      end

      IDX_TCR: begin
        if (!bus_req) begin
          bus_req_d   = 1'b1;
          bus_mode_d  = MODE_INDEX;
          bus_value_d = index_word(REG_TCR);
        end else if (done) begin
          bus_req_d = 1'b0;
          state_d   = DAT_TCR;
        end
      end

      DAT_TCR: begin
        if (!bus_req) begin
          bus_req_d   = 1'b1;
          bus_mode_d  = MODE_DATA;
          bus_value_d = TCR_TXREQ;
        end else if (done) begin
          bus_req_d    = 1'b0;
          state_d      = IDLE;
          frame_sent_d = 1'b1;
          busy_d       = 1'b0;
        end
      end

      default: begin
        state_d   = IDLE;
        bus_req_d = 1'b0;
      end
    endcase

    in_ready_d = (state_d == GET_LO) || (state_d == GET_HI);
  end

  // State and registered outputs with synchronous reset.
  always_ff @(posedge clk100) begin
    if (reset) begin
      state      <= IDLE;
      count      <= '0;
      pad_len    <= '0;
      ovf        <= 1'b0;
      last       <= 1'b0;
      in_ready   <= 1'b0;
      bus_req    <= 1'b0;
      bus_mode   <= MODE_INDEX;
      bus_value  <= 16'h0000;
      busy       <= 1'b0;
      frame_sent <= 1'b0;
      err_len    <= 1'b0;
    end else begin
      state      <= state_d;
      count      <= count_d;
      pad_len    <= pad_len_d;
      ovf        <= ovf_d;
      last       <= last_d;
      in_ready   <= in_ready_d;
      bus_req    <= bus_req_d;
      bus_mode   <= bus_mode_d;
      bus_value  <= bus_value_d;
      busy       <= busy_d;
      frame_sent <= frame_sent_d;
      err_len    <= err_len_d;
    end
  end

endmodule

// File: doc/dm9000a_tx_framer.md
DM9000A_TX_FRAMER -- requirements
Module: dm9000a_tx_framer

Interface
REQ-001 Parameter MAX_FRAME_BYTES, default 1514: largest byte count forwarded per frame.
REQ-002 Parameter MIN_FRAME_BYTES, default 60: frames shorter than this are zero-padded.
REQ-003 Port clk100  in  1: single clock; all logic on its rising edge.
REQ-004 Port reset  in  1: synchronous, active-high reset.
REQ-005 Port in_valid  in  1: upstream byte valid.
REQ-006 Port in_data  in  8: frame byte, destination MAC first.
REQ-007 Port in_last  in  1: marks final byte of frame.
REQ-008 Port in_ready  out  1: byte accepted when in_valid and in_ready are both high.
REQ-009 Port bus_req  out  1: request one DM9000A bus write.
REQ-010 Port bus_mode  out  1: 0 = Index cycle, 1 = Data cycle.
REQ-011 Port bus_value  out  16: index address or data word.
REQ-012 Port bus_done  in  1: one-cycle pulse from bus engine, current write finished.
REQ-013 Port busy  out  1: high from first accepted byte until frame_sent.
REQ-014 Port frame_sent  out  1: one-cycle pulse after TCR trigger write completes.
REQ-015 Port err_len  out  1: one-cycle pulse when frame exceeds MAX_FRAME_BYTES.

Function
REQ-016 The block SHALL hold bus_req, bus_mode and bus_value stable from assertion until the cycle bus_done is sampled high, then deassert bus_req for at least one cycle.
REQ-017 A bus_done pulse while bus_req is low SHALL be ignored.
REQ-018 FSM states SHALL be IDLE, IDX_MWCMD, GET_LO, GET_HI, WR_WORD, PAD, IDX_TXPLL, DAT_TXPLL, IDX_TXPLH, DAT_TXPLH, IDX_TCR, DAT_TCR.
REQ-019 IDLE: in_ready low; on in_valid high, go to IDX_MWCMD and issue Index write of 0x00F8 without consuming the byte.
REQ-020 GET_LO/GET_HI: in_ready high; the first byte of a pair fills bus_value[7:0], the second fills bus_value[15:8].
REQ-021 Once the high byte is accepted, or in_last arrives on the low byte with high byte 0x00, the block SHALL go to WR_WORD and issue a Data write; in_ready SHALL be low during WR_WORD.
REQ-022 A 16-bit byte counter SHALL count accepted bytes; a byte beyond MAX_FRAME_BYTES SHALL be consumed but not written, set a sticky overflow flag, and pulse err_len exactly once per frame.
REQ-023 While overflow is set, the block SHALL keep in_ready high until in_last, then continue with length = MAX_FRAME_BYTES.
REQ-024 After in_last, if length < MIN_FRAME_BYTES, PAD SHALL issue 0x0000 Data writes until the length padded to an even count reaches MIN_FRAME_BYTES; the reported length SHALL then be MIN_FRAME_BYTES.
REQ-025 The tail sequence SHALL be: Index 0x00FC, Data {8'h00,len[7:0]}, Index 0x00FD, Data {8'h00,len[15:8]}, Index 0x0002, Data 0x0001.
REQ-026 frame_sent SHALL pulse the cycle after bus_done for the TCR Data write; the FSM SHALL return to IDLE on that same cycle, and busy SHALL fall with it.
REQ-027 An odd-length frame SHALL report its true odd length; the zero pad byte SHALL NOT be counted.
REQ-028 in_last on the first byte (1-byte frame) SHALL be handled as an odd frame, then padded.

Reset
REQ-029 With reset high at a clock edge, the block SHALL enter IDLE, clear the counter and overflow flag, and drive in_ready, bus_req, busy, frame_sent and err_len to 0, bus_mode to 0, and bus_value to 0x0000.
REQ-030 Reset mid-frame SHALL abandon the frame with no further bus requests; an outstanding bus_done after reset SHALL be ignored.

Structure
REQ-031 DM9000A register indices (MWCMD 0xF8, TXPLL 0xFC, TXPLH 0xFD, TCR 0x02), the Index/Data mode encodings and the FSM state enum SHALL live in package ProtocolInfo.
REQ-032 The block SHALL be a single module with one FSM and no sub-module.

Verification
REQ-033 64-byte frame 0x00..0x3F, bus_done 3 cycles after each req -> Index F8, 32 Data words (first 0x0100), FC/0x0040, FD/0x0000, 02/0x0001, one frame_sent.
REQ-034 3-byte frame AA BB CC -> words 0xBBAA, 0x00CC, 28 pad words 0x0000, length 0x003C written.
REQ-035 61-byte frame -> 31 Data words, last word high byte 0x00, TXPLL data 0x003D.
REQ-036 1520-byte frame -> err_len pulses once at byte 1515, 757 Data words, TXPLL 0xEA, TXPLH 0x05.
REQ-037 Reset asserted after the 10th bus_done of a frame -> bus_req low next cycle, no frame_sent; a following 64-byte frame completes normally.
REQ-038 Spurious bus_done with bus_req low, and in_valid toggling mid-pair -> no state advance, word contents unaffected.
